gr_load_arb: RTL and testbench
==============================

GR_LOAD_ARB -- requirements
Module: gr_load_arb

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single system clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; low forces the reset state immediately, independent of clk.
REQ-004 req0 / req1  in  1 each  load request from requester 0 / requester 1; held high until the matching ack.
REQ-005 op0 / op1  in  2 each  load mode: 00 = LSB nibble, 01 = MSB nibble, 10 = full byte, 11 = split byte.
REQ-006 wdata0 / wdata1  in  8 each  write data from requester 0 / requester 1; meaningful only while the matching req is high.
REQ-007 ack0 / ack1  out  1 each  one-cycle completion pulse to requester 0 / requester 1.
REQ-008 load_lsb_gr / load_msb_gr  out  1 each  nibble load strobes to the general register.
REQ-009 data_on_gr  out  8  data bus to the general register.
REQ-010 busy  out  1  high in every state except IDLE.

Function
REQ-011 States: IDLE, LOAD1, LOAD2, ACK; all outputs come from registers, with no combinational path from inputs to outputs.
REQ-012 IDLE: if no req is high, stay in IDLE with all outputs 0.
REQ-013 IDLE: if any req is high, on the next edge
- grant one requester;
- latch its op and wdata into internal registers;
- go to LOAD1.
REQ-014 Arbitration is round-robin through a 1-bit priority pointer (reset value 0 = requester 0 preferred).
- If both requests are high, grant the preferred requester.
- If one request is high, grant that requester regardless of the pointer.
REQ-015 The pointer updates on exit from ACK to point at the non-granted requester; it does not change otherwise.
REQ-016 LOAD1 outputs (one cycle), by latched op:
- op 00: load_lsb_gr=1, load_msb_gr=0, data_on_gr = {4'h0, wdata[3:0]}.
- op 01: load_lsb_gr=0, load_msb_gr=1, data_on_gr = {4'h0, wdata[3:0]}.
- op 10: both strobes 1, data_on_gr = wdata[7:0].
- op 11: load_lsb_gr=1 only, data_on_gr = {4'h0, wdata[3:0]}.
REQ-017 From LOAD1, op 11 goes to LOAD2; every other op goes to ACK.
REQ-018 LOAD2 (one cycle): load_msb_gr=1, load_lsb_gr=0, data_on_gr = {4'h0, wdata[7:4]}; then go to ACK.
REQ-019 ACK (one cycle): ack of the granted requester = 1, strobes = 0, data_on_gr = 0; then go to IDLE.
REQ-020 Outside LOAD1/LOAD2, both strobes and data_on_gr are 0; the two strobes are never both 1 except for op 10.
REQ-021 Latency from the grant edge to ack high: 2 cycles for op 00/01/10; 3 cycles for op 11.
- Back-to-back service: the next request is sampled in IDLE the cycle after ACK, so each transaction carries 1 idle cycle.
REQ-022 A req that drops before its ack does not abort the transaction; it completes using the latched op/wdata.
REQ-023 Changes to op/wdata after the grant edge have no effect on the transaction in progress.
REQ-024 At most one ack is high in any cycle; ack0 and ack1 are never simultaneous.
REQ-025 A requester that still holds req high in the IDLE cycle after its ack is treated as a new request.

Reset
REQ-026 While reset=0:
- state = IDLE, pointer = 0;
- ack0 = ack1 = 0, load_lsb_gr = load_msb_gr = 0, data_on_gr = 8'h00, busy = 0.
REQ-027 A reset asserted mid-transaction (LOAD1/LOAD2/ACK) aborts it with no ack issued; after release, the FSM resumes from IDLE.
REQ-028 After reset release, the first active clock edge samples requests normally; no extra wait cycle.

Verification
REQ-029 req0 with op 10, wdata 8'hA5 -> LOAD1: both strobes high and data_on_gr = 8'hA5; ack0 pulses 2 cycles after the grant edge.
REQ-030 req1 with op 11, wdata 8'h3C:
- cycle 1: load_lsb_gr with data_on_gr = 8'h0C;
- cycle 2: load_msb_gr with data_on_gr = 8'h03;
- ack1 follows the next cycle.
REQ-031 req0 and req1 both held high from reset, with ops 00 and 01 -> grants alternate in the order 0, 1, 0, 1; acks never overlap.
REQ-032 req1 alone after a serviced req1 -> granted immediately despite the pointer favouring requester 0.
REQ-033 reset pulled low during LOAD2 of an op-11 transfer -> all outputs 0 asynchronously, no ack; after release, a new op-00 request completes normally.
REQ-034 wdata0 changed from 8'h12 to 8'hFF in LOAD1 -> strobe data reflects 8'h12 in every load cycle.

Source files
------------

// File: rtl/gr_load_arb_if.sv
// Request/ack and general-register load signals shared by the two requesters and the arbiter.
// Requesters drive the master side; the arbiter is the slave.
interface gr_load_arb_if;
   logic       req0;
   logic       req1;
   logic [1:0] op0;
   logic [1:0] op1;
   logic [7:0] wdata0;
   logic [7:0] wdata1;
   logic       ack0;
   logic       ack1;
   logic       load_lsb_gr;
   logic       load_msb_gr;
   logic [7:0] data_on_gr;
   logic       busy;

   modport master (
      output req0, req1, op0, op1, wdata0, wdata1,
      input  ack0, ack1, load_lsb_gr, load_msb_gr, data_on_gr, busy
   );

   modport slave (
      input  req0, req1, op0, op1, wdata0, wdata1,
      output ack0, ack1, load_lsb_gr, load_msb_gr, data_on_gr, busy
   );
endinterface

// File: rtl/gr_load_arb.sv
// Round-robin arbiter loading a general register as nibbles or a byte; ack 2 cycles after grant (3 for split).
// No backpressure: a granted transaction always completes, and requests wait high in IDLE until granted.
module gr_load_arb (
   input  logic           clk,
   input  logic           reset,
   gr_load_arb_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, LOAD1, LOAD2, ACK} state_t;

   state_t     state_q, state_d;
   logic       ptr_q, ptr_d;
   logic       gnt_q, gnt_d;
   logic [1:0] op_q, op_d;
   logic [7:0] wdata_q, wdata_d;

   logic       ack0_q, ack0_d;
   logic       ack1_q, ack1_d;
   logic       lsb_q, lsb_d;
   logic       msb_q, msb_d;
   logic [7:0] data_q, data_d;
   logic       busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      op_d    = op_q;
      wdata_d = wdata_q;

      case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               // Pointer only matters on contention; a lone request always wins.
               gnt_d   = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
               op_d    = gnt_d ? bus.op1 : bus.op0;
               wdata_d = gnt_d ? bus.wdata1 : bus.wdata0;
               state_d = LOAD1;
            end
         end
         LOAD1:   state_d = (op_q == 2'b11) ? LOAD2 : ACK;
         LOAD2:   state_d = ACK;
         ACK: begin
            state_d = IDLE;
            ptr_d   = ~gnt_q;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_comb begin
      ack0_d = 1'b0;
      ack1_d = 1'b0;
      lsb_d  = 1'b0;
      msb_d  = 1'b0;
      data_d = 8'h00;
      busy_d = (state_d != IDLE);

      case (state_d)
         LOAD1: begin
            data_d = {4'h0, wdata_d[3:0]};
            case (op_d)
               2'b00: lsb_d = 1'b1;
               2'b01: msb_d = 1'b1;
               2'b10: begin
                  lsb_d  = 1'b1;
                  msb_d  = 1'b1;
                  data_d = wdata_d;
               end
               default: lsb_d = 1'b1;
            endcase
         end
         LOAD2: begin
            msb_d  = 1'b1;
            data_d = {4'h0, wdata_d[7:4]};
         end
         ACK: begin
            ack0_d = ~gnt_d;
            ack1_d = gnt_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         gnt_q   <= 1'b0;
         op_q    <= 2'b00;
         wdata_q <= 8'h00;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         lsb_q   <= 1'b0;
         msb_q   <= 1'b0;
         data_q  <= 8'h00;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         op_q    <= op_d;
         wdata_q <= wdata_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         lsb_q   <= lsb_d;
         msb_q   <= msb_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.ack0        = ack0_q;
   assign bus.ack1        = ack1_q;
   assign bus.load_lsb_gr = lsb_q;
   assign bus.load_msb_gr = msb_q;
   assign bus.data_on_gr  = data_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_gr_load_arb.sv
// Bench for gr_load_arb: directed scenarios plus randomized two-requester traffic against a transaction-level model.
module tb_gr_load_arb;

   typedef struct packed {
      logic       ack0;
      logic       ack1;
      logic       lsb;
      logic       msb;
      logic       busy;
      logic [7:0] data;
   } obs_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   m_ptr    = 1'b0;
   obs_t exp_q[$];

   gr_load_arb_if bus ();

   gr_load_arb dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic obs_t obs_now();
      obs_now = {bus.ack0, bus.ack1, bus.load_lsb_gr, bus.load_msb_gr, bus.busy, bus.data_on_gr};
   endfunction

   function automatic obs_t mk(bit a0, bit a1, bit l, bit m, bit b, logic [7:0] d);
      mk = {a0, a1, l, m, b, d};
   endfunction

   // Transaction-level model: load cycles by op, then the ack; pointer moves to the loser.
   function automatic void model_txn(input bit g, input logic [1:0] op, input logic [7:0] wd);
      case (op)
         2'd0: exp_q.push_back(mk(0, 0, 1, 0, 1, {4'h0, wd[3:0]}));
         2'd1: exp_q.push_back(mk(0, 0, 0, 1, 1, {4'h0, wd[3:0]}));
         2'd2: exp_q.push_back(mk(0, 0, 1, 1, 1, wd));
         default: begin
            exp_q.push_back(mk(0, 0, 1, 0, 1, {4'h0, wd[3:0]}));
            exp_q.push_back(mk(0, 0, 0, 1, 1, {4'h0, wd[7:4]}));
         end
      endcase
      exp_q.push_back(mk(!g, g, 0, 0, 1, 8'h00));
      m_ptr = !g;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.req0 = 0; bus.req1 = 0; bus.op0 = 0; bus.op1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
      #2;
      reset = 1'b0;
      bus.req0 = 1; bus.req1 = 1; bus.op0 = 2'd2; bus.op1 = 2'd3;
      bus.wdata0 = 8'($urandom); bus.wdata1 = 8'($urandom);
      #1;
      n_checks++;
      if (obs_now() !== obs_t'(0)) $display("FAIL reset_async: got %h expected %h", obs_now(), obs_t'(0));
      else n_pass++;
      repeat (3) tick();
      n_checks++;
      if (obs_now() !== obs_t'(0)) $display("FAIL reset_held: got %h expected %h", obs_now(), obs_t'(0));
      else n_pass++;
      to_neg();
      bus.req0 = 0; bus.req1 = 0;
      reset = 1'b1;
      m_ptr = 1'b0;
      tick();
      n_checks++;
      if (obs_now() !== obs_t'(0)) $display("FAIL reset_idle: got %h expected %h", obs_now(), obs_t'(0));
      else n_pass++;
   endtask

   task automatic test_full_byte();
      to_neg();
      bus.req0 = 1; bus.op0 = 2'd2; bus.wdata0 = 8'hA5;
      tick();
      n_checks++;
      if (obs_now() !== mk(0, 0, 1, 1, 1, 8'hA5))
         $display("FAIL full_byte_load: got %h expected %h", obs_now(), mk(0, 0, 1, 1, 1, 8'hA5));
      else n_pass++;
      tick();
      n_checks++;
      if (obs_now() !== mk(1, 0, 0, 0, 1, 8'h00))
         $display("FAIL full_byte_ack: got %h expected %h", obs_now(), mk(1, 0, 0, 0, 1, 8'h00));
      else n_pass++;
      to_neg();
      bus.req0 = 0;
      m_ptr = 1'b1;
      tick();
      n_checks++;
      if (obs_now() !== obs_t'(0)) $display("FAIL full_byte_idle: got %h expected %h", obs_now(), obs_t'(0));
      else n_pass++;
   endtask

   task automatic test_split();
      to_neg();
      bus.req1 = 1; bus.op1 = 2'd3; bus.wdata1 = 8'h3C;
      tick();
      n_checks++;
      if (obs_now() !== mk(0, 0, 1, 0, 1, 8'h0C))
         $display("FAIL split_lsb: got %h expected %h", obs_now(), mk(0, 0, 1, 0, 1, 8'h0C));
      else n_pass++;
      tick();
      n_checks++;
      if (obs_now() !== mk(0, 0, 0, 1, 1, 8'h03))
         $display("FAIL split_msb: got %h expected %h", obs_now(), mk(0, 0, 0, 1, 1, 8'h03));
      else n_pass++;
      tick();
      n_checks++;
      if (obs_now() !== mk(0, 1, 0, 0, 1, 8'h00))
         $display("FAIL split_ack: got %h expected %h", obs_now(), mk(0, 1, 0, 0, 1, 8'h00));
      else n_pass++;
      to_neg();
      bus.req1 = 0;
      m_ptr = 1'b0;
      tick();
      n_checks++;
      if (obs_now() !== obs_t'(0)) $display("FAIL split_idle: got %h expected %h", obs_now(), obs_t'(0));
      else n_pass++;
   endtask

   task automatic test_alternate();
      obs_t e;
      to_neg();
      reset = 1'b0;
      bus.req0 = 1; bus.req1 = 1; bus.op0 = 2'd0; bus.op1 = 2'd1;
      bus.wdata0 = 8'($urandom); bus.wdata1 = 8'($urandom);
      to_neg();
      reset = 1'b1;
      m_ptr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) model_txn(1'b0, bus.op0, bus.wdata0);
         else            model_txn(1'b1, bus.op1, bus.wdata1);
         while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs_now() !== e) $display("FAIL alternate_%0d: got %h expected %h", i, obs_now(), e);
            else n_pass++;
         end
         if (i == 3) begin
            to_neg();
            bus.req0 = 0; bus.req1 = 0;
         end
         tick();
         n_checks++;
         if (obs_now() !== obs_t'(0)) $display("FAIL alternate_idle_%0d: got %h expected %h", i, obs_now(), obs_t'(0));
         else n_pass++;
      end
   endtask

   task automatic test_single_req1();
      obs_t e;
      for (int i = 0; i < 2; i++) begin
         to_neg();
         bus.req1 = 1; bus.op1 = 2'($urandom); bus.wdata1 = 8'($urandom);
         model_txn(1'b1, bus.op1, bus.wdata1);
         while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs_now() !== e) $display("FAIL single_req1_%0d: got %h expected %h", i, obs_now(), e);
            else n_pass++;
         end
         to_neg();
         bus.req1 = 0;
         tick();
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] wd;
      to_neg();
      bus.req0 = 1; bus.op0 = 2'd3; bus.wdata0 = 8'($urandom);
      tick();
      tick();
      n_checks++;
      if (obs_now() !== mk(0, 0, 0, 1, 1, {4'h0, bus.wdata0[7:4]}))
         $display("FAIL mid_reset_load2: got %h expected %h", obs_now(), mk(0, 0, 0, 1, 1, {4'h0, bus.wdata0[7:4]}));
      else n_pass++;
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (obs_now() !== obs_t'(0)) $display("FAIL mid_reset_async: got %h expected %h", obs_now(), obs_t'(0));
      else n_pass++;
      tick();
      n_checks++;
      if (obs_now() !== obs_t'(0)) $display("FAIL mid_reset_no_ack: got %h expected %h", obs_now(), obs_t'(0));
      else n_pass++;
      to_neg();
      reset = 1'b1;
      wd = 8'($urandom);
      bus.op0 = 2'd0; bus.wdata0 = wd;
      m_ptr = 1'b0;
      tick();
      n_checks++;
      if (obs_now() !== mk(0, 0, 1, 0, 1, {4'h0, wd[3:0]}))
         $display("FAIL mid_reset_recover_load: got %h expected %h", obs_now(), mk(0, 0, 1, 0, 1, {4'h0, wd[3:0]}));
      else n_pass++;
      tick();
      n_checks++;
      if (obs_now() !== mk(1, 0, 0, 0, 1, 8'h00))
         $display("FAIL mid_reset_recover_ack: got %h expected %h", obs_now(), mk(1, 0, 0, 0, 1, 8'h00));
      else n_pass++;
      to_neg();
      bus.req0 = 0;
      m_ptr = 1'b1;
      tick();
   endtask

   task automatic test_data_hold();
      obs_t e;
      to_neg();
      bus.req0 = 1; bus.op0 = 2'd3; bus.wdata0 = 8'h12;
      model_txn(1'b0, 2'd3, 8'h12);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (obs_now() !== e) $display("FAIL data_hold_load1: got %h expected %h", obs_now(), e);
      else n_pass++;
      to_neg();
      bus.wdata0 = 8'hFF; bus.op0 = 2'd2; bus.req0 = 0;
      while (exp_q.size() > 0) begin
         tick();
         e = exp_q.pop_front();
         n_checks++;
         if (obs_now() !== e) $display("FAIL data_hold_tail: got %h expected %h", obs_now(), e);
         else n_pass++;
      end
      tick();
      n_checks++;
      if (obs_now() !== obs_t'(0)) $display("FAIL data_hold_idle: got %h expected %h", obs_now(), obs_t'(0));
      else n_pass++;
   endtask

   task automatic test_random();
      obs_t       e;
      bit         pend[2];
      logic [1:0] pop[2];
      logic [7:0] pw[2];
      bit         g;
      int         k;
      pend[0] = 0; pend[1] = 0;
      for (int it = 0; it < 40; it++) begin
         to_neg();
         for (int r = 0; r < 2; r++) begin
            if (!pend[r] && $urandom_range(0, 1) == 1) begin
               pend[r] = 1; pop[r] = 2'($urandom); pw[r] = 8'($urandom);
            end
         end
         if (!pend[0] && !pend[1]) begin
            g = 1'($urandom_range(0, 1));
            pend[g] = 1; pop[g] = 2'($urandom); pw[g] = 8'($urandom);
         end
         bus.req0 = pend[0]; bus.op0 = pop[0]; bus.wdata0 = pw[0];
         bus.req1 = pend[1]; bus.op1 = pop[1]; bus.wdata1 = pw[1];
         g = (pend[0] && pend[1]) ? m_ptr : pend[1];
         model_txn(g, pop[g], pw[g]);
         k = 0;
         while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs_now() !== e) $display("FAIL random_%0d_cyc%0d: got %h expected %h", it, k, obs_now(), e);
            else n_pass++;
            if (k == 0) begin
               to_neg();
               if (g) begin bus.op1 = 2'($urandom); bus.wdata1 = 8'($urandom); end
               else   begin bus.op0 = 2'($urandom); bus.wdata0 = 8'($urandom); end
            end
            k++;
         end
         to_neg();
         pend[g] = 0;
         if (g) bus.req1 = 0; else bus.req0 = 0;
         tick();
         n_checks++;
         if (obs_now() !== obs_t'(0)) $display("FAIL random_%0d_idle: got %h expected %h", it, obs_now(), obs_t'(0));
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_full_byte();
      test_split();
      test_alternate();
      test_single_req1();
      test_reset_mid();
      test_data_hold();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
